// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// The owner_t enum is used for the FSM state, the last grant and the pending read owner.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_t;

endpackage

// File: rtl/data_memory_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker with a lock override for the current owner.
// It returns IDLE when no requester is asking for the memory.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last_grant,
    input  owner_t     i_owner,
    input  logic       i_owner_lock,
    input  logic       i_lock_expired,
    output owner_t     o_winner
);

    logic w_ownerReq;

    assign w_ownerReq = ((i_owner == OWN_A) && i_req[REQ_A]) ||
                        ((i_owner == OWN_B) && i_req[REQ_B]);

    // A locked owner keeps the slot until its streak expires; otherwise alternate on ties.
    always_comb begin
        o_winner = IDLE;
        if (w_ownerReq && i_owner_lock && !i_lock_expired) begin
            o_winner = i_owner;
        end else if (i_req[REQ_A] && i_req[REQ_B]) begin
            o_winner = (i_last_grant == OWN_A) ? OWN_B : OWN_A;
        end else if (i_req[REQ_A]) begin
            o_winner = OWN_A;
        end else if (i_req[REQ_B]) begin
            o_winner = OWN_B;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between requester A and requester B.
// The winning command is registered onto the mem_* lines; read data returns one cycle after the ack.
module data_memory_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);

    owner_t            r_state, r_lastGrant, r_rdPend;
    logic [3:0]        r_lockCnt;
    logic              r_lock, r_ackA, r_ackB, r_memRead, r_memWrite;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    owner_t            w_winner, w_lastGrantNext, w_rdPendNext;
    logic [3:0]        w_lockCntNext;
    logic              w_override, w_lockNext, w_ackANext, w_ackBNext;
    logic              w_memReadNext, w_memWriteNext;
    logic [ADDR_W-1:0] w_addrNext;
    logic [DATA_W-1:0] w_wdataNext;

    rr_arb2 u_arb (
        .i_req         ({b_req, a_req}),
        .i_last_grant  (r_lastGrant),
        .i_owner       (r_state),
        .i_owner_lock  (r_lock),
        .i_lock_expired(r_lockCnt >= LOCK_LAST),
        .o_winner      (w_winner)
    );

    assign w_override = r_lock && (r_lockCnt < LOCK_LAST) &&
                        (r_state != IDLE) && (w_winner == r_state);

    // Next command, ownership and lock streak; address and data hold when nobody wins.
    always_comb begin
        w_lockCntNext   = w_override ? 4'(r_lockCnt + 4'd1) : 4'd0;
        w_lockNext      = 1'b0;
        w_lastGrantNext = r_lastGrant;
        w_addrNext      = r_addr;
        w_wdataNext     = r_wdata;
        w_memReadNext   = 1'b0;
        w_memWriteNext  = 1'b0;
        w_ackANext      = 1'b0;
        w_ackBNext      = 1'b0;
        w_rdPendNext    = r_memRead ? r_state : IDLE;
        case (w_winner)
            OWN_A: begin
                w_lockNext      = a_lock;
                w_lastGrantNext = OWN_A;
                w_addrNext      = a_addr;
                w_wdataNext     = a_wdata;
                w_memReadNext   = ~a_we;
                w_memWriteNext  = a_we;
                w_ackANext      = 1'b1;
            end
            OWN_B: begin
                w_lockNext      = b_lock;
                w_lastGrantNext = OWN_B;
                w_addrNext      = b_addr;
                w_wdataNext     = b_wdata;
                w_memReadNext   = ~b_we;
                w_memWriteNext  = b_we;
                w_ackBNext      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_lastGrant <= OWN_B;
            r_rdPend    <= IDLE;
            r_lockCnt   <= 4'd0;
            r_lock      <= 1'b0;
            r_ackA      <= 1'b0;
            r_ackB      <= 1'b0;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_winner;
            r_lastGrant <= w_lastGrantNext;
            r_rdPend    <= w_rdPendNext;
            r_lockCnt   <= w_lockCntNext;
            r_lock      <= w_lockNext;
            r_ackA      <= w_ackANext;
            r_ackB      <= w_ackBNext;
            r_memRead   <= w_memReadNext;
            r_memWrite  <= w_memWriteNext;
            r_addr      <= w_addrNext;
            r_wdata     <= w_wdataNext;
        end
    end

    assign a_ack         = r_ackA;
    assign b_ack         = r_ackB;
    assign a_rvalid      = (r_rdPend == OWN_A);
    assign b_rvalid      = (r_rdPend == OWN_B);
    assign a_rdata       = a_rvalid ? mem_readdata : '0;
    assign b_rdata       = b_rvalid ? mem_readdata : '0;
    assign mem_address   = r_addr;
    assign mem_writedata = r_wdata;
    assign mem_memread   = r_memRead;
    assign mem_memwrite  = r_memWrite;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model and a behavioural 256x8 memory.
module tb_data_memory_arbiter;

    localparam int LOCK_MAX = 4;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       a_req = 0, a_we = 0, a_lock = 0, b_req = 0, b_we = 0, b_lock = 0;
    logic [7:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
    logic       a_ack, a_rvalid, b_ack, b_rvalid, mem_memread, mem_memwrite;
    logic [7:0] a_rdata, b_rdata, mem_address, mem_writedata, mem_readdata;

    int checks = 0;
    int failures = 0;
    bit checkEn = 0;

    data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(LOCK_MAX)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_readdata(mem_readdata)
    );

    always #5 CLK = ~CLK;

    // Behavioural data memory: reset pattern mem[i] = i, registered read data.
    logic [7:0] memArr [256];
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 256; i++) memArr[i] <= 8'(i);
            mem_readdata <= 8'h00;
        end else begin
            if (mem_memwrite) memArr[mem_address] <= mem_writedata;
            if (mem_memread) mem_readdata <= memArr[mem_address];
        end
    end

    // Transaction-level model: who wins each edge, what lands on the bus, what comes back.
    logic [7:0] refMem [256];
    int         mOwner, mLastWinner, mStreak, mPendWho, mWin;
    bit         mPrevLock, mOwnerReq, mWe, mLock;
    logic [7:0] mPendData, mAddr, mWd;
    logic       expAckA, expAckB, expRvA, expRvB, expRead, expWrite;
    logic [7:0] expRdA, expRdB, expAddr, expWdata;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 256; i++) refMem[i] = 8'(i);
            mOwner = 0; mLastWinner = 2; mStreak = 0; mPendWho = 0; mPrevLock = 0;
            mPendData = 0;
            expAckA = 0; expAckB = 0; expRvA = 0; expRvB = 0; expRead = 0; expWrite = 0;
            expRdA = 0; expRdB = 0; expAddr = 0; expWdata = 0;
        end else begin
            expRvA = (mPendWho == 1);
            expRvB = (mPendWho == 2);
            expRdA = expRvA ? mPendData : 8'h00;
            expRdB = expRvB ? mPendData : 8'h00;
            mPendWho = 0;
            mOwnerReq = (mOwner == 1 && a_req) || (mOwner == 2 && b_req);
            if (mOwner != 0 && mPrevLock && mOwnerReq && mStreak < LOCK_MAX) mWin = mOwner;
            else if (a_req && b_req) mWin = (mLastWinner == 1) ? 2 : 1;
            else if (a_req) mWin = 1;
            else if (b_req) mWin = 2;
            else mWin = 0;
            expAckA = (mWin == 1);
            expAckB = (mWin == 2);
            if (mWin != 0) begin
                mStreak = (mWin == mOwner && mPrevLock && mStreak < LOCK_MAX) ? mStreak + 1 : 1;
                mWe   = (mWin == 1) ? a_we : b_we;
                mLock = (mWin == 1) ? a_lock : b_lock;
                mAddr = (mWin == 1) ? a_addr : b_addr;
                mWd   = (mWin == 1) ? a_wdata : b_wdata;
                expAddr = mAddr; expWdata = mWd; expRead = !mWe; expWrite = mWe;
                if (mWe) refMem[mAddr] = mWd;
                else begin
                    mPendWho = mWin;
                    mPendData = refMem[mAddr];
                end
                mPrevLock = mLock;
                mLastWinner = mWin;
            end else begin
                expRead = 0; expWrite = 0; mPrevLock = 0; mStreak = 0;
            end
            mOwner = mWin;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (checkEn) begin
            checkOutput("cyc_a_ack", 32'(a_ack), 32'(expAckA));
            checkOutput("cyc_b_ack", 32'(b_ack), 32'(expAckB));
            checkOutput("cyc_a_rvalid", 32'(a_rvalid), 32'(expRvA));
            checkOutput("cyc_b_rvalid", 32'(b_rvalid), 32'(expRvB));
            checkOutput("cyc_a_rdata", 32'(a_rdata), 32'(expRdA));
            checkOutput("cyc_b_rdata", 32'(b_rdata), 32'(expRdB));
            checkOutput("cyc_memread", 32'(mem_memread), 32'(expRead));
            checkOutput("cyc_memwrite", 32'(mem_memwrite), 32'(expWrite));
            checkOutput("cyc_mem_address", 32'(mem_address), 32'(expAddr));
            checkOutput("cyc_mem_writedata", 32'(mem_writedata), 32'(expWdata));
            checkOutput("cyc_rw_exclusive", 32'(mem_memread & mem_memwrite), 32'd0);
        end
    end

    task automatic applyStimulus(input logic aR, input logic aW, input logic aL,
                                 input logic [7:0] aA, input logic [7:0] aD,
                                 input logic bR, input logic bW, input logic bL,
                                 input logic [7:0] bA, input logic [7:0] bD);
        a_req = aR; a_we = aW; a_lock = aL; a_addr = aA; a_wdata = aD;
        b_req = bR; b_we = bW; b_lock = bL; b_addr = bA; b_wdata = bD;
    endtask

    task automatic idleInputs();
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_outs"}, {24'd0, a_ack, a_rvalid, b_ack, b_rvalid, mem_memread, mem_memwrite, 2'b00}, 32'd0);
        checkOutput({tag, "_data"}, {a_rdata, b_rdata, mem_address, mem_writedata}, 32'd0);
    endtask

    task automatic resetDut();
        idleInputs();
        @(posedge CLK); #2;
        RESET_N = 0;
        tick(); tick();
        RESET_N = 1;
        tick();
    endtask

    int grants [8];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        idleInputs();
        tick(); tick();
        checkAllZero("reset");
        RESET_N = 1;
        tick();
        checkEn = 1;

        // Single A read of 0x10 returns the reset pattern.
        applyStimulus(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        tick();
        idleInputs();
        checkOutput("t1_a_ack", 32'(a_ack), 32'd1);
        checkOutput("t1_memread", 32'(mem_memread), 32'd1);
        checkOutput("t1_address", 32'(mem_address), 32'h10);
        checkOutput("t1_b_quiet", {29'd0, b_ack, b_rvalid, |b_rdata}, 32'd0);
        tick();
        checkOutput("t1_a_rvalid", 32'(a_rvalid), 32'd1);
        checkOutput("t1_a_rdata", 32'(a_rdata), 32'h10);
        checkOutput("t1_model_rdata", 32'(expRdA), 32'h10);
        checkOutput("t1_a_ack_drop", 32'(a_ack), 32'd0);

        // Tie after reset: A write first, B read next sees the new data.
        resetDut();
        applyStimulus(1, 1, 0, 8'h20, 8'hAA, 1, 0, 0, 8'h20, 8'h00);
        tick();
        checkOutput("t2_first_a", {30'd0, a_ack, b_ack}, 32'b10);
        tick();
        checkOutput("t2_then_b", {30'd0, a_ack, b_ack}, 32'b01);
        tick();
        checkOutput("t2_alt_a", {30'd0, a_ack, b_ack}, 32'b10);
        checkOutput("t2_b_rvalid", 32'(b_rvalid), 32'd1);
        checkOutput("t2_b_rdata", 32'(b_rdata), 32'hAA);
        checkOutput("t2_model_rdata", 32'(expRdB), 32'hAA);
        tick();
        checkOutput("t2_alt_b", {30'd0, a_ack, b_ack}, 32'b01);
        idleInputs();
        tick();

        // Lock starvation bound: four A grants, one B, then A again.
        resetDut();
        applyStimulus(1, 0, 1, 8'h05, 8'h00, 1, 0, 0, 8'h06, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            grants[i] = a_ack ? 1 : (b_ack ? 2 : 0);
        end
        idleInputs();
        for (int i = 0; i < 4; i++) checkOutput("t3_lock_a", 32'(grants[i]), 32'd1);
        checkOutput("t3_then_b", 32'(grants[4]), 32'd2);
        checkOutput("t3_a_resumes", 32'(grants[5]), 32'd1);
        tick();

        // Back-to-back A reads with no bubble.
        resetDut();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, 0, 0, 8'(i), 8'h00, 0, 0, 0, 8'h00, 8'h00);
            tick();
            checkOutput("t4_ack", 32'(a_ack), 32'd1);
            if (i > 1) checkOutput("t4_rdata", {23'd0, a_rvalid, a_rdata}, 32'h100 | 32'(i - 1));
        end
        idleInputs();
        tick();
        checkOutput("t4_last_rdata", {23'd0, a_rvalid, a_rdata}, 32'h103);
        checkOutput("t4_no_ack", 32'(a_ack), 32'd0);

        // Reset during the ack cycle of a B read discards it.
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h30, 8'h00);
        tick();
        idleInputs();
        checkOutput("t5_b_ack", 32'(b_ack), 32'd1);
        #2;
        RESET_N = 0;
        #1;
        checkAllZero("t5_async");
        tick();
        checkAllZero("t5_held");
        RESET_N = 1;
        tick();
        checkOutput("t5_no_rvalid", 32'(b_rvalid), 32'd0);
        applyStimulus(1, 0, 0, 8'h31, 8'h00, 1, 0, 0, 8'h32, 8'h00);
        tick();
        idleInputs();
        checkOutput("t5_tie_to_a", {30'd0, a_ack, b_ack}, 32'b10);
        tick();

        // Write, idle five cycles, read back.
        applyStimulus(1, 1, 0, 8'h40, 8'h5A, 0, 0, 0, 8'h00, 8'h00);
        tick();
        idleInputs();
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t6_idle", {28'd0, mem_memread, mem_memwrite, a_ack, b_ack}, 32'd0);
        end
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h40, 8'h00);
        tick();
        idleInputs();
        tick();
        checkOutput("t6_readback", {23'd0, b_rvalid, b_rdata}, 32'h15A);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)), 8'($urandom),
                          1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)), 8'($urandom));
            tick();
        end
        idleInputs();
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
